// File: rtl/garuda_pkg.sv
// Shared garuda definitions: bank lifecycle states and default lane geometry.
package garuda_pkg;

  typedef enum logic [1:0] {
    BANK_FREE  = 2'd0,
    BANK_FILL  = 2'd1,
    BANK_READY = 2'd2
  } bank_state_e;

  localparam int DEF_NUM_LANES  = 16;
  localparam int DEF_LANE_WIDTH = 32;
  localparam int DEF_DEPTH      = 8;

endpackage

// File: rtl/lane_bank_ram.sv
// One bank of row storage: a single write port and a registered read port.
module lane_bank_ram #(
  parameter int ROW_W = 512,
  parameter int DEPTH = 8,
  parameter int RW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we,
  input  logic [RW-1:0]    waddr,
  input  logic [ROW_W-1:0] wdata,
  input  logic             re,
  input  logic [RW-1:0]    raddr,
  output logic [ROW_W-1:0] rdata
);

  logic [ROW_W-1:0] mem [DEPTH];

  // Storage itself is never cleared; only the output register resets.
  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/lane_pingpong_buffer.sv
// Two-bank ping-pong row buffer between a wide DMA output bus and a row-indexed consumer.
// Handshake: a row transfers on a rising edge where in_valid_i and in_ready_o are both high.
module lane_pingpong_buffer
  import garuda_pkg::*;
#(
  parameter int NUM_LANES  = DEF_NUM_LANES,
  parameter int LANE_WIDTH = DEF_LANE_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  localparam int ROW_W     = NUM_LANES * LANE_WIDTH,
  localparam int RW        = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic [ROW_W-1:0] in_data_i,
  output logic             in_ready_o,
  input  logic             flush_i,
  output logic             out_valid_o,
  output logic             out_bank_o,
  output logic [RW:0]      out_rows_o,
  input  logic             rd_en_i,
  input  logic [RW-1:0]    rd_row_i,
  output logic [ROW_W-1:0] rd_data_o,
  output logic             rd_valid_o,
  input  logic             release_i,
  output logic             err_o
);

  bank_state_e bank_state_q [2];
  bank_state_e bank_state_d [2];
  logic [RW:0] rows_q [2];
  logic [RW:0] rows_d [2];
  logic [RW:0] wr_cnt_q, wr_cnt_d, cnt_next;
  logic        wr_bank_q, wr_bank_d;
  logic        rd_bank_q, rd_bank_d;
  logic        err_q, err_d;
  logic        rd_valid_q, rd_sel_q;
  logic        rst_done_q;
  logic        accept, close, release_ok, rd_ok;
  logic [ROW_W-1:0] bank_rdata [2];

  // in_ready_o stays low until the first edge after reset is released.
  assign in_ready_o  = rst_done_q && (bank_state_q[wr_bank_q] != BANK_READY);
  assign out_valid_o = (bank_state_q[rd_bank_q] == BANK_READY);
  assign out_bank_o  = rd_bank_q;
  assign out_rows_o  = rows_q[rd_bank_q];
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = bank_rdata[rd_sel_q];
  assign err_o       = err_q;

  assign accept     = in_valid_i && in_ready_o;
  assign cnt_next   = wr_cnt_q + (RW+1)'(accept);
  // A flush on the DEPTH-th row folds into the same single close.
  assign close      = (accept && (cnt_next == (RW+1)'(DEPTH))) ||
                      (flush_i && (cnt_next != '0));
  assign release_ok = release_i && out_valid_o;
  assign rd_ok      = rd_en_i && out_valid_o && ({1'b0, rd_row_i} < out_rows_o);

  always_comb begin
    bank_state_d = bank_state_q;
    rows_d       = rows_q;
    wr_cnt_d     = cnt_next;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    err_d        = err_q | (rd_en_i && !rd_ok) | (release_i && !out_valid_o);
    // Release and close never target the same bank: the write bank is never READY when it can close.
    if (release_ok) begin
      bank_state_d[rd_bank_q] = BANK_FREE;
      rd_bank_d               = ~rd_bank_q;
    end
    if (close) begin
      bank_state_d[wr_bank_q] = BANK_READY;
      rows_d[wr_bank_q]       = cnt_next;
      wr_cnt_d                = '0;
      wr_bank_d               = ~wr_bank_q;
    end else if (accept) begin
      bank_state_d[wr_bank_q] = BANK_FILL;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bank_state_q[0] <= BANK_FREE;
      bank_state_q[1] <= BANK_FREE;
      rows_q[0]       <= '0;
      rows_q[1]       <= '0;
      wr_cnt_q        <= '0;
      wr_bank_q       <= 1'b0;
      rd_bank_q       <= 1'b0;
      err_q           <= 1'b0;
      rd_valid_q      <= 1'b0;
      rd_sel_q        <= 1'b0;
      rst_done_q      <= 1'b0;
    end else begin
      bank_state_q <= bank_state_d;
      rows_q       <= rows_d;
      wr_cnt_q     <= wr_cnt_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      err_q        <= err_d;
      rd_valid_q   <= rd_ok;
      if (rd_ok) rd_sel_q <= rd_bank_q;
      rst_done_q   <= 1'b1;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    lane_bank_ram #(
      .ROW_W (ROW_W),
      .DEPTH (DEPTH),
      .RW    (RW)
    ) u_ram (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .we    (accept && (wr_bank_q == 1'(b))),
      .waddr (wr_cnt_q[RW-1:0]),
      .wdata (in_data_i),
      .re    (rd_ok && (rd_bank_q == 1'(b))),
      .raddr (rd_row_i),
      .rdata (bank_rdata[b])
    );
  end

endmodule

// File: tb/tb_lane_pingpong_buffer.sv
// Directed bench for lane_pingpong_buffer: fill, flush, backpressure, release overlap, reset.
module tb_lane_pingpong_buffer;

  localparam int NUM_LANES  = 16;
  localparam int LANE_WIDTH = 32;
  localparam int DEPTH      = 8;
  localparam int ROW_W      = NUM_LANES * LANE_WIDTH;
  localparam int RW         = $clog2(DEPTH);

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             in_valid_i;
  logic [ROW_W-1:0] in_data_i;
  logic             in_ready_o;
  logic             flush_i;
  logic             out_valid_o;
  logic             out_bank_o;
  logic [RW:0]      out_rows_o;
  logic             rd_en_i;
  logic [RW-1:0]    rd_row_i;
  logic [ROW_W-1:0] rd_data_o;
  logic             rd_valid_o;
  logic             release_i;
  logic             err_o;

  int n_checks = 0;
  int n_errors = 0;

  // Clock and reset
  always #5 clk_i = ~clk_i;

  lane_pingpong_buffer #(
    .NUM_LANES  (NUM_LANES),
    .LANE_WIDTH (LANE_WIDTH),
    .DEPTH      (DEPTH)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_bank_o  (out_bank_o),
    .out_rows_o  (out_rows_o),
    .rd_en_i     (rd_en_i),
    .rd_row_i    (rd_row_i),
    .rd_data_o   (rd_data_o),
    .rd_valid_o  (rd_valid_o),
    .release_i   (release_i),
    .err_o       (err_o)
  );

  // Lane 0 carries v; lane k carries v + (k << 16) so every lane is distinct.
  function automatic logic [ROW_W-1:0] mk_row(input logic [LANE_WIDTH-1:0] v);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_LANES; k++) r[k*LANE_WIDTH +: LANE_WIDTH] = v + (k << 16);
    return r;
  endfunction

  task automatic check(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge, outputs sampled there too.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [LANE_WIDTH-1:0] v);
    in_valid_i = 1'b1;
    in_data_i  = mk_row(v);
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic rd(input int r);
    rd_en_i  = 1'b1;
    rd_row_i = RW'(r);
    tick();
    rd_en_i  = 1'b0;
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
  endtask

  task automatic do_release();
    release_i = 1'b1;
    tick();
    release_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; in_valid_i = 1'b0; in_data_i = '0; flush_i = 1'b0;
    rd_en_i = 1'b0; rd_row_i = '0; release_i = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_in_ready",  ROW_W'(in_ready_o),  '0);
    check("rst_out_valid", ROW_W'(out_valid_o), '0);
    check("rst_out_rows",  ROW_W'(out_rows_o),  '0);
    check("rst_rd_valid",  ROW_W'(rd_valid_o),  '0);
    check("rst_rd_data",   rd_data_o,           '0);
    check("rst_err",       ROW_W'(err_o),       '0);
    rst_i = 1'b0;
    #1;
    check("deassert_in_ready_low", ROW_W'(in_ready_o), '0);
    tick();
    check("first_edge_in_ready", ROW_W'(in_ready_o), ROW_W'(1));

    // Full bank of 8 rows, read row 3
    for (int i = 1; i <= 8; i++) push(LANE_WIDTH'(i));
    check("full_out_valid", ROW_W'(out_valid_o), ROW_W'(1));
    check("full_out_rows",  ROW_W'(out_rows_o),  ROW_W'(8));
    check("full_out_bank",  ROW_W'(out_bank_o),  ROW_W'(0));
    check("full_in_ready",  ROW_W'(in_ready_o),  ROW_W'(1));
    rd(3);
    check("full_rd_valid", ROW_W'(rd_valid_o), ROW_W'(1));
    check("full_rd_data",  rd_data_o,          mk_row(32'h4));
    check("full_err",      ROW_W'(err_o),      '0);
    do_release();
    check("rel0_out_valid", ROW_W'(out_valid_o), '0);
    check("rel0_out_bank",  ROW_W'(out_bank_o),  ROW_W'(1));

    // Partial bank: 3 rows then flush, out-of-range read
    for (int i = 0; i < 3; i++) push(LANE_WIDTH'(32'h11 + i));
    check("part_not_ready_yet", ROW_W'(out_valid_o), '0);
    do_flush();
    check("part_out_valid", ROW_W'(out_valid_o), ROW_W'(1));
    check("part_out_rows",  ROW_W'(out_rows_o),  ROW_W'(3));
    check("part_out_bank",  ROW_W'(out_bank_o),  ROW_W'(1));
    rd(3);
    check("oob_rd_valid", ROW_W'(rd_valid_o), '0);
    check("oob_err",      ROW_W'(err_o),      ROW_W'(1));
    rd(2);
    check("part_rd_data", rd_data_o, mk_row(32'h13));
    do_release();
    check("rel1_out_bank", ROW_W'(out_bank_o), '0);
    check("rel1_out_valid", ROW_W'(out_valid_o), '0);

    // Both banks full: backpressure, then release one
    for (int i = 0; i < 16; i++) push(LANE_WIDTH'(32'h20 + i));
    check("both_in_ready", ROW_W'(in_ready_o), '0);
    check("both_out_bank", ROW_W'(out_bank_o), '0);
    push(32'hff);
    rd(7);
    check("both_rd_b0r7", rd_data_o, mk_row(32'h27));
    do_release();
    check("both_rel_in_ready",  ROW_W'(in_ready_o),  ROW_W'(1));
    check("both_rel_out_bank",  ROW_W'(out_bank_o),  ROW_W'(1));
    check("both_rel_out_valid", ROW_W'(out_valid_o), ROW_W'(1));
    rd(0);
    check("both_rd_b1r0", rd_data_o, mk_row(32'h28));

    // 8th row and flush together close bank 0 once
    for (int i = 0; i < 7; i++) push(LANE_WIDTH'(32'h30 + i));
    flush_i = 1'b1;
    push(32'h37);
    flush_i = 1'b0;
    check("flush8_in_ready", ROW_W'(in_ready_o), '0);
    check("flush8_out_bank", ROW_W'(out_bank_o), ROW_W'(1));
    do_release();
    check("flush8_rows",     ROW_W'(out_rows_o),  ROW_W'(8));
    check("flush8_bank",     ROW_W'(out_bank_o),  '0);
    check("flush8_b1_free",  ROW_W'(in_ready_o),  ROW_W'(1));
    do_flush();
    check("empty_flush_noop_bank",  ROW_W'(out_bank_o), '0);
    check("empty_flush_noop_ready", ROW_W'(in_ready_o), ROW_W'(1));

    // Release bank 0 in the same cycle as the 8th row of bank 1
    for (int i = 0; i < 7; i++) push(LANE_WIDTH'(32'h40 + i));
    check("pre_overlap_out_bank", ROW_W'(out_bank_o), '0);
    release_i = 1'b1;
    push(32'h47);
    release_i = 1'b0;
    check("overlap_out_valid", ROW_W'(out_valid_o), ROW_W'(1));
    check("overlap_out_bank",  ROW_W'(out_bank_o),  ROW_W'(1));
    check("overlap_out_rows",  ROW_W'(out_rows_o),  ROW_W'(8));
    check("overlap_in_ready",  ROW_W'(in_ready_o),  ROW_W'(1));
    rd(7);
    check("overlap_rd_data", rd_data_o, mk_row(32'h47));
    check("err_sticky",      ROW_W'(err_o), ROW_W'(1));

    // Reset mid-fill
    for (int i = 0; i < 5; i++) push(LANE_WIDTH'(32'h50 + i));
    rst_i = 1'b1;
    #1;
    check("midrst_in_ready",  ROW_W'(in_ready_o),  '0);
    check("midrst_out_valid", ROW_W'(out_valid_o), '0);
    check("midrst_err",       ROW_W'(err_o),       '0);
    check("midrst_rd_data",   rd_data_o,           '0);
    tick();
    rst_i = 1'b0;
    tick();
    check("postrst_in_ready",  ROW_W'(in_ready_o),  ROW_W'(1));
    check("postrst_out_valid", ROW_W'(out_valid_o), '0);
    push(32'h55);
    do_flush();
    check("postrst_rows",  ROW_W'(out_rows_o), ROW_W'(1));
    check("postrst_bank",  ROW_W'(out_bank_o), '0);
    rd(0);
    check("postrst_rd_data",  rd_data_o,          mk_row(32'h55));
    check("postrst_rd_valid", ROW_W'(rd_valid_o), ROW_W'(1));
    rd(1);
    check("postrst_oob_valid", ROW_W'(rd_valid_o), '0);
    check("postrst_oob_err",   ROW_W'(err_o),      ROW_W'(1));

    // Final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lane_pingpong_buffer.md
LANE_PINGPONG_BUFFER -- requirements
Module: lane_pingpong_buffer

Interface
REQ-001 Parameter NUM_LANES, default 16: number of lanes, matching the DMA wide output bus.
REQ-002 Parameter LANE_WIDTH, default 32: bits per lane; ROW_W = NUM_LANES*LANE_WIDTH.
REQ-003 Parameter DEPTH, default 8: rows per bank, power of two, at least 2; RW = $clog2(DEPTH).
REQ-004 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 in_valid_i  in  1  wide row offered by the DMA engine.
REQ-007 in_data_i  in  ROW_W  row data, lane 0 in bits [LANE_WIDTH-1:0].
REQ-008 in_ready_o  out  1  row accepted this cycle when high with in_valid_i.
REQ-009 flush_i  in  1  close a partially filled write bank.
REQ-010 out_valid_o  out  1  read bank is READY for the consumer.
REQ-011 out_bank_o  out  1  index of the current read bank.
REQ-012 out_rows_o  out  RW+1  valid row count of the read bank (1..DEPTH).
REQ-013 rd_en_i  in  1  row read request.
REQ-014 rd_row_i  in  RW  row index within the read bank.
REQ-015 rd_data_o  out  ROW_W  registered read data.
REQ-016 rd_valid_o  out  1  rd_data_o valid.
REQ-017 release_i  in  1  consumer finished with the read bank.
REQ-018 err_o  out  1  sticky protocol error flag.

Function
REQ-019 Two banks of DEPTH x ROW_W; each bank state is FREE, FILL or READY.
REQ-020 wr_bank selects the target bank; in_ready_o = (target bank is FREE or FILL).
REQ-021 An accepted row is written at row wr_cnt of wr_bank; the bank becomes FILL and wr_cnt increments.
REQ-022 When the accepted row makes wr_cnt == DEPTH, the bank becomes READY next cycle, stores its row count, wr_cnt clears, wr_bank toggles.
REQ-023 flush_i with wr_cnt > 0 closes the bank as in REQ-022 with count = wr_cnt (including a row accepted that same cycle).
REQ-024 flush_i with wr_cnt == 0 and no row accepted is a no-op.
REQ-025 Flush coinciding with the DEPTH-th row closes the bank once, with count DEPTH.
REQ-026 rd_bank points to the oldest READY bank; out_valid_o = (bank[rd_bank] == READY); out_bank_o = rd_bank.
REQ-027 A bank closed in cycle N raises out_valid_o in cycle N+1 if it is the read bank.
REQ-028 rd_en_i with out_valid_o and rd_row_i < out_rows_o: rd_data_o and rd_valid_o are driven the next cycle (1-cycle latency).
REQ-029 rd_en_i without out_valid_o, or with rd_row_i >= out_rows_o: rd_valid_o stays low and err_o is set.
REQ-030 release_i with out_valid_o frees bank[rd_bank] and toggles rd_bank next cycle.
REQ-031 release_i without out_valid_o is ignored and sets err_o.
REQ-032 A write-side close and a read-side release in the same cycle are both honoured; a freed bank accepts writes from the next cycle.
REQ-033 When both banks are READY, in_ready_o is low, with no loss or overwrite of data.
REQ-034 Row order is preserved: banks are consumed in fill order, rows by index.
REQ-035 err_o clears only on reset.

Reset
REQ-036 Reset sets both banks FREE, wr_bank = rd_bank = 0, wr_cnt = 0, and all outputs low or zero.
REQ-037 Reset forces all outputs low or zero, including in_ready_o, until the first edge after deassertion; in_ready_o is 1 from that cycle onward.
REQ-038 Reset mid-fill or mid-read discards all banked data; memory contents need not be cleared.

Structure
REQ-039 The bank state enum (FREE/FILL/READY) and the default lane constants live in the shared garuda package.
REQ-040 Bank storage is a sub-module lane_bank_ram: 1 write port and 1 registered read port, instantiated once per bank.

Verification
REQ-041 Write 8 rows 0x1..0x8 (lane 0) -> out_valid_o=1 the next cycle, out_rows_o=8, out_bank_o=0; reading row 3 returns 0x4 one cycle later.
REQ-042 Write 3 rows then flush_i -> out_rows_o=3; rd_row_i=3 -> rd_valid_o=0 and err_o=1.
REQ-043 Write 16 rows without release -> in_ready_o=0 after row 16; release_i -> in_ready_o=1 the next cycle, out_bank_o=1.
REQ-044 The 8th row and flush_i in the same cycle -> a single close with out_rows_o=8; the next bank stays FREE.
REQ-045 release_i of bank 0 in the same cycle as the 8th row of bank 1 -> out_valid_o stays 1, out_bank_o=1, bank 0 is writable.
REQ-046 rst_i asserted after 5 rows -> in_ready_o=1 and out_valid_o=0 after deassertion; a new flush after 1 row gives out_rows_o=1.
